// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// Holds the funct3 encodings, the FSM state type and the divide special-case helper.
package muldiv_pkg;

   localparam int XLEN = 32;
   localparam int CW   = $clog2(XLEN);

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] val;
   } md_spec_t;

   // Divide by zero and signed overflow finish in one cycle with a fixed result.
   function automatic md_spec_t md_special(
      input logic [2:0]      f3,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      md_spec_t s;
      s.hit = 1'b0;
      s.val = '0;
      if (f3[2]) begin
         if (b == '0) begin
            s.hit = 1'b1;
            s.val = f3[1] ? a : '1;
         end else if (!f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
            s.hit = 1'b1;
            s.val = f3[1] ? '0 : a;
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Shift-add multiply / restoring divide datapath for the M-extension sequencer.
// Product and remainder:quotient share one 2*XLEN register (hi:lo).
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            finish_i,
   input  logic            special_i,
   input  logic [XLEN-1:0] special_val_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o
);

   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              sgn_a, sgn_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN-1:0]   hi, lo;
   logic [XLEN:0]     sh, sum;
   logic [XLEN+1:0]   diff;
   logic [2*XLEN-1:0] stepped, neg64, mul_src;
   logic [XLEN-1:0]   div_word, fin_word;

   always_comb begin
      sgn_a = a_i[XLEN-1] && funct3_i != MD_MULHU
           && funct3_i != MD_DIVU && funct3_i != MD_REMU;
      sgn_b = b_i[XLEN-1] && (funct3_i == MD_MUL || funct3_i == MD_MULH
           || funct3_i == MD_DIV || funct3_i == MD_REM);
      mag_a = sgn_a ? -a_i : a_i;
      mag_b = sgn_b ? -b_i : b_i;

      hi   = prod_q[2*XLEN-1:XLEN];
      lo   = prod_q[XLEN-1:0];
      sh   = {hi, lo[XLEN-1]};
      diff = {1'b0, sh} - {2'b00, mcand_q};
      sum  = lo[0] ? ({1'b0, hi} + {1'b0, mcand_q}) : {1'b0, hi};

      if (f3_q[2]) begin
         if (!diff[XLEN+1])
            stepped = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
         else
            stepped = {sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      end else begin
         stepped = {sum, lo[XLEN-1:1]};
      end

      // High-word multiplies need a full-width negate, not a per-word one.
      neg64    = -stepped;
      mul_src  = neg_q ? neg64 : stepped;
      div_word = f3_q[1] ? stepped[2*XLEN-1:XLEN] : stepped[XLEN-1:0];
      if (f3_q[2])
         fin_word = neg_q ? -div_word : div_word;
      else if (f3_q == MD_MUL)
         fin_word = mul_src[XLEN-1:0];
      else
         fin_word = mul_src[2*XLEN-1:XLEN];

      f3_d    = f3_q;
      neg_d   = neg_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      res_d   = res_q;
      if (load_i) begin
         f3_d    = funct3_i;
         neg_d   = (funct3_i[2] && funct3_i[1]) ? sgn_a : (sgn_a ^ sgn_b);
         mcand_d = mag_b;
         prod_d  = {{XLEN{1'b0}}, mag_a};
         if (special_i)
            res_d = special_val_i;
      end else if (step_i) begin
         prod_d = stepped;
         if (finish_i)
            res_d = fin_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f3_q    <= '0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         prod_q  <= '0;
         res_q   <= '0;
      end else begin
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         res_q   <= res_d;
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer in EX: stalls the front end while one bit per
// cycle is processed, then pulses MDValid with the result for one cycle.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            MulDivE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            FlushE,
   output logic            StallMD,
   output logic            MDValid,
   output logic [XLEN-1:0] MDResult,
   output logic            Busy
);

   md_state_e state_q;
   logic [CW-1:0] cnt_q;
   md_spec_t spec;
   logic accept, step, finish;

   assign spec   = md_special(funct3E, SrcAE, SrcBE);
   assign accept = state_q == MD_IDLE && MulDivE && !FlushE;
   assign step   = state_q == MD_BUSY && !FlushE;
   assign finish = step && cnt_q == '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            MD_IDLE: begin
               if (accept) begin
                  state_q <= spec.hit ? MD_DONE : MD_BUSY;
                  cnt_q   <= CW'(XLEN-1);
               end
            end
            MD_BUSY: begin
               if (FlushE)
                  state_q <= MD_IDLE;
               else if (cnt_q == '0)
                  state_q <= MD_DONE;
               else
                  cnt_q <= cnt_q - CW'(1);
            end
            MD_DONE: state_q <= MD_IDLE;
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign StallMD = accept || state_q == MD_BUSY;
   assign MDValid = state_q == MD_DONE && !FlushE;
   assign Busy    = state_q != MD_IDLE;

   muldiv_datapath u_dp (
      .clk           (clk),
      .rst           (rst),
      .load_i        (accept),
      .step_i        (step),
      .finish_i      (finish),
      .special_i     (spec.hit),
      .special_val_i (spec.val),
      .funct3_i      (funct3E),
      .a_i           (SrcAE),
      .b_i           (SrcBE),
      .result_o      (MDResult)
   );

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts an M-extension operation using the post-forwarding operands, runs a one-bit-per-cycle shift-add multiply or restoring divide, and holds the front of the pipeline (IF/ID/EX) while it runs. It releases the result in a single cycle, and that result is muxed into ALUOutM in place of ALUOutE.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- MulDivE  in  1  the instruction in EX is an M-extension op (opcode 0110011, funct7 0000001).
- funct3E  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE, SrcBE  in  XLEN  operands after the forwarding muxes.
- FlushE  in  1  kills the EX instruction, including any in-flight operation.
- StallMD  out  1  combinational; freezes the IF/ID/EX registers and inserts a bubble into MEM.
- MDValid  out  1  one-cycle pulse; MDResult replaces ALUOutE at the EX/MEM register this cycle.
- MDResult  out  XLEN  registered result.
- Busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** if MulDivE & !FlushE, accept the request:
  - Latch funct3 and operand magnitudes, plus the result sign.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Special cases (divide ops only) go directly to DONE with a fixed result:
    - B == 0: DIV/DIVU give all-ones; REM/REMU give A.
    - DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: the quotient is 0x80000000 and the remainder is 0.
  - Otherwise go to BUSY with the counter set to XLEN-1.
- **BUSY:**
  - Multiply: add-and-shift on magnitudes into a 2·XLEN product register, one bit per cycle.
  - Divide: restoring shift/subtract, one quotient bit per cycle.
  - When the counter reaches 0, go to DONE. On that transition, apply sign correction (two's-complement negate) and select the word into MDResult:
    - MUL: low word. MULH/MULHSU/MULHU: high word.
    - Quotient sign = sA^sB. Remainder sign = sign of the dividend.
- **DONE:** MDValid = !FlushE. Next state is IDLE unconditionally.
- StallMD = (IDLE & MulDivE & !FlushE) | BUSY. StallMD is low in DONE, so the instruction leaves EX with its result.
- FlushE in BUSY: go to IDLE next cycle; MDValid is never raised and the result is discarded.
- FlushE in DONE: MDValid is suppressed.
- FlushE in IDLE: no accept.
- A new M-op entering EX right after DONE is accepted in the following IDLE cycle. There is no lost or duplicate accept.
- MDResult holds its last value outside DONE.

## Timing
- Reset (synchronous, rst high at the clock edge): state IDLE, counter 0, MDResult 0, MDValid 0, StallMD 0, Busy 0. Reset mid-BUSY aborts the operation with no MDValid.
- Normal op accepted at cycle T:
  - BUSY for cycles T+1..T+XLEN.
  - DONE with MDValid at T+XLEN+1 (T+33 for XLEN=32).
  - StallMD is high for T..T+XLEN, i.e. 33 cycles.
- Special case accepted at T: DONE/MDValid at T+1; StallMD is high only at T.
- Operands are sampled only at accept. Changes to forwarded values during the stall are ignored.

## Structure
- Shared package muldiv_pkg holds:
  - funct3 constants MD_MUL..MD_REMU.
  - State encoding MD_IDLE/MD_BUSY/MD_DONE.
  - XLEN default.
- One sub-module, muldiv_datapath, contains:
  - Product/remainder and quotient shift registers.
  - Adder/subtractor and negation logic.
  - It is driven by load/step/finish strobes from the FSM in muldiv_sequencer.

## Test plan
- MUL 7 × 0xFFFFFFFD accepted at T -> StallMD high T..T+32; MDValid at T+33 with MDResult 0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF with MDValid at T+1.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- FlushE at T+10 -> state IDLE at T+11, StallMD low, no MDValid.
- rst at T+20 -> all outputs 0 next cycle.
- Back-to-back MUL then DIVU: MulDivE is high again after DONE -> second accept on the cycle after DONE; exactly two MDValid pulses with correct results.
